// File: rtl/tff_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tff_ctrl_pkg
// Shared definitions for the T-flip-flop modulo counter controller:
//   - state_t         : controller state encodings (ST_IDLE, ST_RUN, ST_DONE)
//   - mod_legal()     : elaboration-time check that 2 <= MOD <= 2**WIDTH
//   - toggle_mask()   : per-bit toggle enables that move a T-cell bank from
//                       its current value to a chosen target value
// ST_DONE is only ever entered when TFF_CTRL_SATURATE_EN is defined.
// -----------------------------------------------------------------------------
package tff_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Modulus must fit the cell bank and leave at least two distinct counts.
  function automatic bit mod_legal(input int width, input int modv);
    if (width < 1 || width > 30) return 1'b0;
    return (modv >= 2) && (modv <= (1 << width));
  endfunction

  // A T cell toggles when its enable is 1, so toggling exactly the bits that
  // differ between the current and target values lands the bank on target.
  function automatic logic [31:0] toggle_mask(input logic [31:0] cur,
                                              input logic [31:0] target);
    return cur ^ target;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// -----------------------------------------------------------------------------
// tff_cell
// One T flip-flop with a synchronous reload path.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset, clears q
//   t    in  toggle enable
//   load in  reload request, takes d (has priority over t)
//   d    in  reload value
//   q    out cell output
// -----------------------------------------------------------------------------
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic load,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (load) begin
      q <= d;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_mod_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tff_mod_counter_ctrl
// Run/stop, loadable, up/down modulo-MOD counter built from WIDTH T cells.
// The controller only ever computes per-bit toggle enables; the cells hold the
// count and are written directly only by a load.
// Parameters:
//   WIDTH  number of T cells / count bits
//   modulus parameter, 2 <= MOD <= 2**WIDTH
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   start       in   begin counting (IDLE only)
//   stop        in   halt counting (RUN only, beats counting)
//   dir         in   1 = up, 0 = down, sampled every RUN cycle
//   load_valid  in   load request
//   load_val    in   load value, clamped to MOD-1
//   load_ready  out  load accepted when load_valid & load_ready
//   q           out  current count
//   tc          out  one-cycle pulse when q first shows the wrapped value
//   busy        out  high while in RUN
// Configuration macro: TFF_CTRL_SATURATE_EN
//   defined   : counting stops at MOD-1 (up) or 0 (down), pulses tc and parks
//               in DONE until a load returns to IDLE
//   undefined : modulo wrap, DONE is never entered
// -----------------------------------------------------------------------------
module tff_mod_counter_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_val,
  output logic             load_ready,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  if (!mod_legal(WIDTH, MOD)) begin : g_bad_mod
    $error("tff_mod_counter_ctrl: MOD out of range for WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

  state_t           state;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] load_clamped;
  logic             load_fire;
  logic             adv;
  logic             at_top;
  logic             at_bot;
  logic             tc_hit;

  assign load_fire    = load_valid & load_ready;
  assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;
  assign adv          = (state == ST_RUN) && !stop;
  assign at_top       = (q == MAX_Q);
  assign at_bot       = (q == '0);

  // Ripple-style enables: bit i toggles when all lower bits are 1 (up) or
  // all lower bits are 0 (down); bit 0 always toggles.
  always_comb begin
    logic acc_up;
    logic acc_dn;
    acc_up = 1'b1;
    acc_dn = 1'b1;
    up_t   = '0;
    dn_t   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = acc_up;
      dn_t[i] = acc_dn;
      acc_up  = acc_up & q[i];
      acc_dn  = acc_dn & ~q[i];
    end
  end

`ifdef TFF_CTRL_SATURATE_EN
  // Saturating: stepping onto the terminal value pulses tc; sitting on it
  // already when RUN advances holds the count and still pulses tc.
  always_comb begin
    t      = '0;
    tc_hit = 1'b0;
    if (adv) begin
      if (dir) begin
        if (at_top) begin
          tc_hit = 1'b1;
        end else begin
          t      = up_t;
          tc_hit = (q == MAX_Q - WIDTH'(1));
        end
      end else begin
        if (at_bot) begin
          tc_hit = 1'b1;
        end else begin
          t      = dn_t;
          tc_hit = (q == WIDTH'(1));
        end
      end
    end
  end
`else
  // Modulo: the wrap step cannot use the ripple enables when MOD is not a
  // power of two, so the cells are toggled straight onto the wrap target.
  always_comb begin
    t      = '0;
    tc_hit = 1'b0;
    if (adv) begin
      if (dir) begin
        if (at_top) begin
          t      = WIDTH'(toggle_mask(32'(q), 32'(0)));
          tc_hit = 1'b1;
        end else begin
          t = up_t;
        end
      end else begin
        if (at_bot) begin
          t      = WIDTH'(toggle_mask(32'(q), 32'(MAX_Q)));
          tc_hit = 1'b1;
        end else begin
          t = dn_t;
        end
      end
    end
  end
`endif

  // Controller FSM; busy, load_ready and tc are registered alongside state so
  // none of them has a combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tc         <= 1'b0;
      busy       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      tc <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!load_fire && start) begin
            state      <= ST_RUN;
            busy       <= 1'b1;
            load_ready <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            load_ready <= 1'b1;
          end else if (tc_hit) begin
            tc <= 1'b1;
`ifdef TFF_CTRL_SATURATE_EN
            state      <= ST_DONE;
            busy       <= 1'b0;
            load_ready <= 1'b1;
`endif
          end
        end
`ifdef TFF_CTRL_SATURATE_EN
        ST_DONE: begin
          if (load_fire) begin
            state <= ST_IDLE;
          end
        end
`endif
        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cells
    tff_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .t    (t[g]),
      .load (load_fire),
      .d    (load_clamped[g]),
      .q    (q[g])
    );
  end

endmodule

// File: tb/tb_tff_mod_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tff_mod_counter_ctrl
// Directed bench for tff_mod_counter_ctrl (WIDTH=4, MOD=10). A count-level
// model tracks what q/tc/busy/load_ready must be after every edge; a compare
// process checks the DUT against it each cycle, and literal checks pin the
// model at the interesting points. Follows TFF_CTRL_SATURATE_EN if defined.
// -----------------------------------------------------------------------------
module tb_tff_mod_counter_ctrl;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic             dir;
  logic             load_valid;
  logic [WIDTH-1:0] load_val;
  logic             load_ready;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;

  int checks = 0;
  int errors = 0;
  bit compare_en = 1'b0;

  // Model: mode 0 = idle, 1 = run, 2 = done
  int m_mode = 0;
  int m_q    = 0;
  bit m_tc   = 1'b0;

  tff_mod_counter_ctrl #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .dir        (dir),
    .load_valid (load_valid),
    .load_val   (load_val),
    .load_ready (load_ready),
    .q          (q),
    .tc         (tc),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Model update from the rules: inputs are stable around the rising edge.
  always @(posedge clk) begin
    int lv;
    lv   = int'(load_val);
    m_tc = 1'b0;
    if (rst) begin
      m_mode = 0;
      m_q    = 0;
    end else if (m_mode == 0 || m_mode == 2) begin
      if (load_valid) begin
        m_q    = (lv > MOD - 1) ? MOD - 1 : lv;
        m_mode = 0;
      end else if (start && m_mode == 0) begin
        m_mode = 1;
      end
    end else if (!stop) begin
`ifdef TFF_CTRL_SATURATE_EN
      if (dir) begin
        if (m_q != MOD - 1) m_q = m_q + 1;
        if (m_q == MOD - 1) begin m_tc = 1'b1; m_mode = 2; end
      end else begin
        if (m_q != 0) m_q = m_q - 1;
        if (m_q == 0) begin m_tc = 1'b1; m_mode = 2; end
      end
`else
      if (dir) begin
        m_q  = (m_q + 1) % MOD;
        m_tc = (m_q == 0);
      end else begin
        m_tc = (m_q == 0);
        m_q  = (m_q + MOD - 1) % MOD;
      end
`endif
    end else begin
      m_mode = 0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (compare_en) begin
      checkOutput("q", int'(q), m_q);
      checkOutput("tc", int'(tc), int'(m_tc));
      checkOutput("busy", int'(busy), int'(m_mode == 1));
      checkOutput("load_ready", int'(load_ready), int'(m_mode != 1));
    end
  end

  // Drive one cycle of inputs, then step past the next rising edge.
  task automatic applyStimulus(input logic r, input logic st, input logic sp,
                               input logic d, input logic lvld,
                               input logic [WIDTH-1:0] lval, input int cycles);
    rst        = r;
    start      = st;
    stop       = sp;
    dir        = d;
    load_valid = lvld;
    load_val   = lval;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    applyStimulus(1, 0, 0, 1, 0, 4'd0, 2);
    compare_en = 1'b1;
    checkOutput("reset_q", int'(q), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_load_ready", int'(load_ready), 1);
    checkOutput("reset_tc", int'(tc), 0);

`ifdef TFF_CTRL_SATURATE_EN
    applyStimulus(0, 1, 0, 1, 0, 4'd0, 1);
    checkOutput("sat_start_q", int'(q), 0);
    applyStimulus(0, 0, 0, 1, 0, 4'd0, 9);
    checkOutput("sat_top_q", int'(q), 9);
    checkOutput("sat_top_tc", int'(tc), 1);
    checkOutput("sat_done_busy", int'(busy), 0);
    applyStimulus(0, 1, 0, 1, 0, 4'd0, 2);
    checkOutput("sat_hold_q", int'(q), 9);
    checkOutput("sat_hold_tc", int'(tc), 0);
    applyStimulus(0, 0, 0, 1, 1, 4'd3, 1);
    checkOutput("sat_load_q", int'(q), 3);
    checkOutput("sat_load_ready", int'(load_ready), 1);
    applyStimulus(0, 1, 0, 0, 0, 4'd0, 1);
    checkOutput("sat_restart_busy", int'(busy), 1);
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 3);
    checkOutput("sat_bottom_q", int'(q), 0);
    checkOutput("sat_bottom_tc", int'(tc), 1);
    applyStimulus(0, 0, 0, 0, 1, 4'd9, 1);
    applyStimulus(0, 1, 0, 1, 0, 4'd0, 2);
    checkOutput("sat_entry_top_q", int'(q), 9);
    checkOutput("sat_entry_top_tc", int'(tc), 1);
`else
    // Count up through a full wrap.
    applyStimulus(0, 1, 0, 1, 0, 4'd0, 1);
    checkOutput("start_busy", int'(busy), 1);
    checkOutput("start_q", int'(q), 0);
    applyStimulus(0, 0, 0, 1, 0, 4'd0, 9);
    checkOutput("up_q9", int'(q), 9);
    checkOutput("up_q9_tc", int'(tc), 0);
    applyStimulus(0, 0, 0, 1, 0, 4'd0, 1);
    checkOutput("wrap_up_q", int'(q), 0);
    checkOutput("wrap_up_tc", int'(tc), 1);
    applyStimulus(0, 0, 0, 1, 0, 4'd0, 4);
    checkOutput("up_q4", int'(q), 4);
    // Stop at 4.
    applyStimulus(0, 0, 1, 1, 0, 4'd0, 1);
    checkOutput("stop_q", int'(q), 4);
    checkOutput("stop_busy", int'(busy), 0);
    checkOutput("stop_load_ready", int'(load_ready), 1);
    // Load beats start; then count down through a wrap.
    applyStimulus(0, 1, 0, 0, 1, 4'd7, 1);
    checkOutput("load7_q", int'(q), 7);
    checkOutput("load7_busy", int'(busy), 0);
    applyStimulus(0, 1, 0, 0, 0, 4'd0, 1);
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 7);
    checkOutput("down_q0", int'(q), 0);
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 1);
    checkOutput("wrap_down_q", int'(q), 9);
    checkOutput("wrap_down_tc", int'(tc), 1);
    // Clamped load.
    applyStimulus(0, 0, 1, 0, 0, 4'd0, 1);
    applyStimulus(0, 0, 0, 0, 1, 4'd12, 1);
    checkOutput("load12_q", int'(q), 9);
    // Reset mid-run at 6.
    applyStimulus(0, 1, 0, 1, 0, 4'd0, 1);
    applyStimulus(0, 0, 0, 1, 0, 4'd0, 7);
    checkOutput("pre_reset_q", int'(q), 6);
    applyStimulus(1, 1, 0, 1, 1, 4'd5, 1);
    checkOutput("midrun_reset_q", int'(q), 0);
    checkOutput("midrun_reset_busy", int'(busy), 0);
    checkOutput("midrun_reset_tc", int'(tc), 0);
    // Direction change mid-run.
    applyStimulus(0, 1, 0, 1, 0, 4'd0, 1);
    applyStimulus(0, 0, 0, 1, 0, 4'd0, 2);
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 3);
    checkOutput("dir_change_q", int'(q), 9);
    checkOutput("dir_change_tc", int'(tc), 1);
`endif

    // Mixed pseudo-random traffic, checked by the model each cycle.
    for (int i = 0; i < 150; i++) begin
      applyStimulus(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 12) == 0), ($urandom_range(0, 5) != 0),
                    ($urandom_range(0, 10) == 0), WIDTH'($urandom_range(0, 15)), 1);
    end

    compare_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
